// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB3-Lite SRAM slave with byte lanes, configurable wait states and ERROR responses
// Ports: HCLK/HRESET (sync, active-high); AHB address phase HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY;
// HBURST/HPROT/HMASTLOCK accepted but ignored; data phase HWDATA in, HRDATA/HREADYOUT/HRESP out.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int AW = $clog2(MEM_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d, wr_q, wr_d;
    logic [1:0]      size_q, size_d, off_q, off_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     mem_q [MEM_DEPTH];
    logic            rdy, accept, err, done;
    logic [3:0]      be;
    logic            unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};
    always_comb begin
        rdy     = state_q == IDLE || state_q == ERR2;
        accept  = rdy & HSEL & HREADY & HTRANS[1];
        err     = (HSIZE > 3'd2) | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0])
                | ({1'b0, HADDR} >= (HADDR_SIZE+1)'(4 * MEM_DEPTH));
        // a legal transfer completes in IDLE once any wait states have elapsed
        done    = state_q == IDLE & pend_q;
        be      = size_q == 2'd2 ? 4'hF : size_q == 2'd1 ? (off_q[1] ? 4'hC : 4'h3) : 4'b0001 << off_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        size_d  = size_q;
        off_d   = off_q;
        idx_d   = idx_q;
        if (rdy) begin
            state_d = accept ? (err ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE)) : IDLE;
            pend_d  = accept & ~err;
            cnt_d   = accept & ~err ? 3'(WAIT_STATES) : 3'd0;
            if (accept) begin
                wr_d   = HWRITE;
                size_d = HSIZE[1:0];
                off_d  = HADDR[1:0];
                idx_d  = HADDR[AW+1:2];
            end
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q == 3'd1 ? IDLE : WAIT;
        end else begin
            state_d = ERR2;
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
        end
    end
    // storage is not reset; a write lands on its completing edge so the next read sees it directly
    always_ff @(posedge HCLK) begin
        if (done & wr_q & ~HRESET)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
    assign HREADYOUT = rdy;
    assign HRESP     = state_q == ERR1 || state_q == ERR2;
    assign HRDATA    = done & ~wr_q ? mem_q[idx_q] : '0;
endmodule

// File: doc/ahb3lite_sram_slave.md
AHB3LITE_SRAM_SLAVE -- requirements
Module: ahb3lite_sram_slave

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width; fixed at 32.
- MEM_DEPTH, 1024, number of 32-bit words of storage.
- WAIT_STATES, 0, data-phase wait cycles per OKAY transfer; range 0..7.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK, in, 1, the single clock.
- HRESET, in, 1, synchronous active-high reset.
- HSEL, in, 1, slave select.
- HADDR, in, HADDR_SIZE, byte address.
- HWDATA, in, 32, write data.
- HRDATA, out, 32, read data.
- HWRITE, in, 1, 1 = write.
- HSIZE, in, 3, transfer size.
- HBURST, in, 3, burst type; ignored.
- HPROT, in, 4, protection; ignored.
- HTRANS, in, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK, in, 1, ignored.
- HREADY, in, 1, bus ready.
- HREADYOUT, out, 1, slave ready.
- HRESP, out, 1, 0 = OKAY, 1 = ERROR.

REQ-003 The block SHALL use one clock, HCLK; reset SHALL be synchronous and active-high on HRESET.

Function
REQ-004 Address phase SHALL be accepted on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; the block SHALL latch HADDR, HWRITE and HSIZE.
REQ-005 On acceptance with HSEL=0, or with HTRANS IDLE/BUSY, the next cycle SHALL be a zero-wait OKAY data phase with no memory access.
REQ-006 The FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-007 An accepted transfer SHALL be an error if any of the following holds:
- HSIZE > 2;
- HADDR is not aligned to 2^HSIZE bytes;
- HADDR >= 4*MEM_DEPTH.
REQ-008 For an error transfer, IDLE SHALL go to ERR1, then ERR2, then IDLE.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- No memory write SHALL occur.
REQ-009 For a legal transfer with WAIT_STATES=N>0, the FSM SHALL go to WAIT and hold HREADYOUT=0, HRESP=0 for exactly N cycles via a down-counter, then drive HREADYOUT=1, HRESP=0 for one cycle.
REQ-010 With WAIT_STATES=0, a legal transfer SHALL complete in the cycle following the address phase with HREADYOUT=1.
REQ-011 While HREADYOUT=0, HADDR/HTRANS SHALL NOT be sampled; pipelined address acceptance SHALL resume on the completing cycle.
REQ-012 A write SHALL sample HWDATA on the completing edge (HREADYOUT=1) and update only the byte lanes selected by HSIZE and HADDR[1:0], little-endian:
- byte: lane HADDR[1:0];
- halfword: lanes {HADDR[1],0} and {HADDR[1],1};
- word: all four lanes.
REQ-013 A read SHALL drive the full 32-bit word at HADDR[..:2] on HRDATA during its completing cycle; HRDATA SHALL be 0 in all other cycles.
REQ-014 A read immediately following a write to the same word SHALL return the newly written bytes (write-to-read forwarding, no extra wait).
REQ-015 Back-to-back NONSEQ/SEQ transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.
REQ-016 An error data phase followed by a pipelined address SHALL accept that address only on the ERR2 cycle.
REQ-017 Memory contents SHALL NOT be reset; reading never-written words returns undefined data.

Reset
REQ-018 While HRESET=1, and on the first cycle after its release:
- FSM SHALL be IDLE;
- HREADYOUT=1, HRESP=0, HRDATA=0;
- the wait counter SHALL be 0;
- any latched transfer SHALL be discarded.
REQ-019 HRESET asserted mid-transfer (WAIT, ERR1 or ERR2) SHALL abort it; a pending write SHALL NOT modify memory.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Word write 0xDEADBEEF @0x10, then word read @0x10, WAIT_STATES=0 -> read completes next cycle, HRDATA=0xDEADBEEF, HRESP=0.
- Halfword writes 0x1234 @0x20 and 0xABCD @0x22, then word read @0x20 -> HRDATA=0xABCD1234.
- Halfword read @0x21 (misaligned) -> HREADYOUT 0 then 1 with HRESP=1 both cycles, no memory change.
- WAIT_STATES=3, word read @0x10 -> HREADYOUT low exactly 3 cycles, then high with data.
- Back-to-back pipelined write 0x55AA55AA @0x30 then read @0x30 -> read returns 0x55AA55AA with no stall.
- HRESET asserted during WAIT of a write to @0x40 -> HREADYOUT=1, HRESP=0 next cycle; later read @0x40 shows old value.
